eth_tx_arbiter: RTL

Packet-granular round-robin arbiter that shares one 10G MAC TX AXI-Stream port between two requesters. Typical requesters are the encap forwarding path and the KV-response/injection path, both 64-bit AXIS on clk156. Once a frame is granted, it is held to its tlast, so frames never interleave at the MAC. The block sits between the requesters and the MAC s_axis_tx interface.

---
 rtl/eth_pkg.sv | 22 ++
 rtl/axis_mux2.sv | 60 ++++++
 rtl/eth_tx_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet-side definitions: AXIS widths and the TX arbiter state encoding.
package eth_pkg;

  localparam int ETH_DATA_WIDTH = 64;
  localparam int ETH_KEEP_WIDTH = ETH_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  // One-hot owner for a given arbiter state; 00 when idle.
  function automatic logic [1:0] arb_grant_onehot(input arb_state_t state);
    logic [1:0] onehot;
    onehot = 2'b00;
    if (state == ARB_GNT0) onehot = 2'b01;
    if (state == ARB_GNT1) onehot = 2'b10;
    return onehot;
  endfunction

endpackage

// File: rtl/axis_mux2.sv
// Combinational 2:1 AXI-Stream mux selected by a one-hot grant.
// Unselected or idle selection drives every output to zero; the MAC's
// tready is returned only to the selected slave.
module axis_mux2 #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic [1:0]            i_sel,
  input  logic                  i_s0_tvalid,
  output logic                  o_s0_tready,
  input  logic [DATA_WIDTH-1:0] i_s0_tdata,
  input  logic [KEEP_WIDTH-1:0] i_s0_tkeep,
  input  logic                  i_s0_tlast,
  input  logic                  i_s0_tuser,
  input  logic                  i_s1_tvalid,
  output logic                  o_s1_tready,
  input  logic [DATA_WIDTH-1:0] i_s1_tdata,
  input  logic [KEEP_WIDTH-1:0] i_s1_tkeep,
  input  logic                  i_s1_tlast,
  input  logic                  i_s1_tuser,
  output logic                  o_m_tvalid,
  input  logic                  i_m_tready,
  output logic [DATA_WIDTH-1:0] o_m_tdata,
  output logic [KEEP_WIDTH-1:0] o_m_tkeep,
  output logic                  o_m_tlast,
  output logic                  o_m_tuser
);

  // Route the selected slave to the master and backpressure to its owner only.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_m_tvalid  = 1'b0;
    o_m_tdata   = '0;
    o_m_tkeep   = '0;
    o_m_tlast   = 1'b0;
    o_m_tuser   = 1'b0;
    o_s0_tready = 1'b0;
    o_s1_tready = 1'b0;
    case (i_sel)
      2'b01: begin
        o_m_tvalid  = i_s0_tvalid;
        o_m_tdata   = i_s0_tdata;
        o_m_tkeep   = i_s0_tkeep;
        o_m_tlast   = i_s0_tlast;
        o_m_tuser   = i_s0_tuser;
        o_s0_tready = i_m_tready;
      end
      2'b10: begin
        o_m_tvalid  = i_s1_tvalid;
        o_m_tdata   = i_s1_tdata;
        o_m_tkeep   = i_s1_tkeep;
        o_m_tlast   = i_s1_tlast;
        o_m_tuser   = i_s1_tuser;
        o_s1_tready = i_m_tready;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one MAC TX AXIS port between
// two requesters. A grant is held until the owner's tlast handshake, so
// frames never interleave. Optional statistics counters are compiled in
// with the macro ETH_TX_ARB_STATS_EN.
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH = ETH_DATA_WIDTH,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk156,
  input  logic                  eth_rst_n,
  input  logic                  s_axis_in0_tvalid,
  output logic                  s_axis_in0_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_in0_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_in0_tkeep,
  input  logic                  s_axis_in0_tlast,
  input  logic                  s_axis_in0_tuser,
  input  logic                  s_axis_in1_tvalid,
  output logic                  s_axis_in1_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_in1_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_in1_tkeep,
  input  logic                  s_axis_in1_tlast,
  input  logic                  s_axis_in1_tuser,
  output logic                  m_axis_tx_tvalid,
  input  logic                  m_axis_tx_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tx_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tx_tkeep,
  output logic                  m_axis_tx_tlast,
  output logic                  m_axis_tx_tuser,
  output logic [1:0]            grant,
  output logic                  busy
`ifdef ETH_TX_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  frame_cnt0,
  output logic [CNT_WIDTH-1:0]  frame_cnt1,
  output logic [CNT_WIDTH-1:0]  contend_cnt
`endif
);

  arb_state_t r_state;
  arb_state_t w_next_state;
  logic       r_last_grant;  // 0 = port 0 owned last, 1 = port 1 owned last
  logic       w_eof0;
  logic       w_eof1;
  logic       w_contend;

  // End-of-frame handshakes of the current owner, and IDLE contention.
  assign w_eof0    = (r_state == ARB_GNT0) & s_axis_in0_tvalid & m_axis_tx_tready & s_axis_in0_tlast;
  assign w_eof1    = (r_state == ARB_GNT1) & s_axis_in1_tvalid & m_axis_tx_tready & s_axis_in1_tlast;
  assign w_contend = (r_state == ARB_IDLE) & s_axis_in0_tvalid & s_axis_in1_tvalid;

  // State register.
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so all flops update together.
    if (!eth_rst_n) r_state <= ARB_IDLE;
    else            r_state <= w_next_state;
  end

  // Next-state: round-robin pick in IDLE, hold the grant until tlast.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ARB_IDLE: begin
        if (s_axis_in0_tvalid && s_axis_in1_tvalid)
          w_next_state = r_last_grant ? ARB_GNT0 : ARB_GNT1;
        else if (s_axis_in0_tvalid)
          w_next_state = ARB_GNT0;
        else if (s_axis_in1_tvalid)
          w_next_state = ARB_GNT1;
      end
      ARB_GNT0: if (w_eof0) w_next_state = ARB_IDLE;
      ARB_GNT1: if (w_eof1) w_next_state = ARB_IDLE;
      default:  w_next_state = ARB_IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    grant = arb_grant_onehot(r_state);
    busy  = (r_state != ARB_IDLE);
  end

  // Remember which port finished the most recent frame.
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n)  r_last_grant <= 1'b1;
    else if (w_eof0) r_last_grant <= 1'b0;
    else if (w_eof1) r_last_grant <= 1'b1;
  end

  axis_mux2 #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH)
  ) u_mux (
    .i_sel       (grant),
    .i_s0_tvalid (s_axis_in0_tvalid),
    .o_s0_tready (s_axis_in0_tready),
    .i_s0_tdata  (s_axis_in0_tdata),
    .i_s0_tkeep  (s_axis_in0_tkeep),
    .i_s0_tlast  (s_axis_in0_tlast),
    .i_s0_tuser  (s_axis_in0_tuser),
    .i_s1_tvalid (s_axis_in1_tvalid),
    .o_s1_tready (s_axis_in1_tready),
    .i_s1_tdata  (s_axis_in1_tdata),
    .i_s1_tkeep  (s_axis_in1_tkeep),
    .i_s1_tlast  (s_axis_in1_tlast),
    .i_s1_tuser  (s_axis_in1_tuser),
    .o_m_tvalid  (m_axis_tx_tvalid),
    .i_m_tready  (m_axis_tx_tready),
    .o_m_tdata   (m_axis_tx_tdata),
    .o_m_tkeep   (m_axis_tx_tkeep),
    .o_m_tlast   (m_axis_tx_tlast),
    .o_m_tuser   (m_axis_tx_tuser)
  );

`ifdef ETH_TX_ARB_STATS_EN
  // Statistics: per-port completed frames and IDLE contention cycles, wrapping.
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      frame_cnt0  <= '0;
      frame_cnt1  <= '0;
      contend_cnt <= '0;
    end else begin
      if (w_eof0)    frame_cnt0  <= frame_cnt0 + 1'b1;
      if (w_eof1)    frame_cnt1  <= frame_cnt1 + 1'b1;
      if (w_contend) contend_cnt <= contend_cnt + 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused = w_contend;
`endif

endmodule
